board_io_ctrl: RTL
==================

Name: board_io_ctrl

Overview:
- Parametrised board-level I/O front end between the FPGA pins and the processor's memory-mapped I/O ports.
- Switch/button path: synchronises and debounces the raw switches and buttons; generates one-cycle button press pulses.
- Display path: decodes per-digit hex nibbles into seven-segment patterns with per-digit blanking; registers the LED outputs.
- Replaces fixed-width pin wiring; channel counts, debounce time and segment polarity are set by parameters.

Parameters:
- NUM_SW, 10, number of slide switches.
- NUM_BTN, 4, number of push buttons; raw button pins are active-low.
- NUM_HEX, 8, number of seven-segment digits.
- NUM_LEDR, 18, number of red LEDs.
- NUM_LEDG, 9, number of green LEDs.
- DEBOUNCE_CYC, 500000, cycles an input must stay stable before it is accepted; minimum 1.
- HEX_ACTIVE_LOW, 1, 1 = segment lit by driving 0; 0 = lit by driving 1.
- REPEAT_DELAY, 25000000, cycles a button is held before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses (optional feature only).

Ports:
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, reset; one clock, synchronous, active-low.
- i_sw_raw, in, NUM_SW, raw asynchronous switch pins.
- i_btn_raw, in, NUM_BTN, raw asynchronous button pins, active-low.
- o_sw, out, NUM_SW, debounced switch levels.
- o_btn, out, NUM_BTN, debounced button levels, active-high (1 = pressed).
- o_btn_press, out, NUM_BTN, one-cycle pulse per accepted press.
- i_hex_val, in, 4*NUM_HEX, nibble k drives digit k.
- i_hex_blank, in, NUM_HEX, 1 = digit k dark.
- o_hex, out, 7*NUM_HEX, segments; digit k at [7k+6:7k], bit order g..a (bit 0 = a).
- i_ledr, in, NUM_LEDR, red LED request.
- i_ledg, in, NUM_LEDG, green LED request.
- o_ledr, out, NUM_LEDR, registered red LEDs.
- o_ledg, out, NUM_LEDG, registered green LEDs.

Behaviour:
Reset (sampled on a rising edge with i_rst_n=0):
- o_sw=0, o_btn=0, o_btn_press=0, o_ledr=0, o_ledg=0.
- o_hex = all segments off: 7'h7F per digit if HEX_ACTIVE_LOW, else 7'h00.
- Synchroniser flops preset to idle: switches 0, buttons released (raw 1).
- All debounce and repeat counters cleared.
- Reset asserted mid-debounce or mid-hold discards the pending state; after release a held button must debounce again before it is accepted.

Input path, independently per bit:
- 2-flop synchroniser, then debounce.
- Button bits are inverted after the synchroniser.
- Debounce counter width is $clog2(DEBOUNCE_CYC+1).
- If the synced value equals the stable value, the counter clears.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1, the stable value takes the synced value and the counter clears.
- A glitch shorter than DEBOUNCE_CYC cycles never reaches the output: the counter restarts from 0 when the input returns to the stable value.
- Latency from a clean edge on a raw pin to the output: 2 + DEBOUNCE_CYC cycles.

Press pulse:
- o_btn_press[i] is 1 for exactly the cycle after o_btn[i] goes 0->1.
- Release (1->0) never generates a pulse.
- Simultaneous presses on several buttons give simultaneous pulses.

Display path:
- Registered, 1-cycle latency from i_hex_val/i_hex_blank to o_hex.
- Standard 0-F patterns, active-high form (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- The pattern is inverted when HEX_ACTIVE_LOW=1.
- Blank overrides the value for that digit.

LEDs:
- o_ledr/o_ledg register i_ledr/i_ledg with 1-cycle latency; no other processing.

Optional Feature:
BOARD_IO_AUTOREPEAT_EN
- Defined:
  - Each button has its own hold counter, running while o_btn[i]=1.
  - Extra o_btn_press[i] pulses fire REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while the button stays held.
  - Release or reset clears the counter immediately; no pulse is emitted on the release cycle.
- Undefined:
  - Exactly one pulse per press.
  - No hold counters are synthesised; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
Bench uses DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset with i_sw_raw=10'h3FF and i_btn_raw=0 held -> during reset o_sw=0, o_btn=0, o_hex=56'hFF..FF (7'h7F per digit), LEDs 0; after release o_sw=10'h3FF at cycle 6 and o_btn=4'hF at cycle 6, with o_btn_press=4'hF pulsing one cycle later.
2. Switch glitches: sw[3] 0->1 for 3 cycles then back -> o_sw[3] stays 0; sw[3] held 1 -> o_sw[3]=1 exactly 6 cycles after the raw edge.
3. btn[1] raw 1->0 held 20 cycles, then 0->1 -> o_btn[1] rises after 6 cycles; exactly one o_btn_press[1] pulse; no pulse on release (feature undefined).
4. With BOARD_IO_AUTOREPEAT_EN defined, btn[2] held 30 cycles after acceptance -> pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28; none after release.
5. i_hex_val=32'h0123ABCF, i_hex_blank=8'h80 -> next cycle digit0=~71 (F), digit1=~39 (C), digit4=~4F (3), digit7=7F (blank).
6. i_ledr=18'h2AAAA, i_ledg=9'h155 -> o_ledr/o_ledg equal them one cycle later; assert i_rst_n=0 mid-debounce of sw[0] -> outputs return to reset values on the next edge and the debounce restarts from 0.

Source files
------------

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board-level I/O front end between FPGA pins and memory-mapped I/O.
//
// Switch/button path: each raw pin is brought through a 2-flop synchroniser and
// debounced. Buttons are active-low on the pins. They are inverted after the
// synchroniser so that o_btn reads 1 while a button is pressed. A one-cycle
// o_btn_press pulse fires in the cycle after o_btn rises.
//
// Display path: the hex nibbles are decoded into registered seven-segment
// patterns, and each digit can be blanked. The red and green LEDs are
// registered with no other processing.
//
// Optional build macro BOARD_IO_AUTOREPEAT_EN: when it is defined, each button
// also has a hold counter. While the button stays held, the counter emits
// extra press pulses, the first REPEAT_DELAY cycles after the initial pulse and
// then one every REPEAT_PERIOD cycles.
//
// Ports:
//   i_clk, i_rst_n           clock; synchronous active-low reset
//   i_sw_raw / o_sw          raw switch pins / debounced switch levels
//   i_btn_raw / o_btn        raw active-low buttons / debounced, active-high
//   o_btn_press              one-cycle pulse per accepted press (plus repeats)
//   i_hex_val, i_hex_blank   nibble and blank control per digit
//   o_hex                    segments, digit k at [7k+6:7k], bit 0 = segment a
//   i_ledr/i_ledg, o_ledr/o_ledg  LED requests and their registered outputs
module board_io_ctrl #(
  parameter int unsigned NUM_SW         = 10,
  parameter int unsigned NUM_BTN        = 4,
  parameter int unsigned NUM_HEX        = 8,
  parameter int unsigned NUM_LEDR       = 18,
  parameter int unsigned NUM_LEDG       = 9,
  parameter int unsigned DEBOUNCE_CYC   = 500000,
  parameter bit          HEX_ACTIVE_LOW = 1'b1,
  parameter int unsigned REPEAT_DELAY   = 25000000,
  parameter int unsigned REPEAT_PERIOD  = 5000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_SW-1:0]      i_sw_raw,
  input  logic [NUM_BTN-1:0]     i_btn_raw,
  output logic [NUM_SW-1:0]      o_sw,
  output logic [NUM_BTN-1:0]     o_btn,
  output logic [NUM_BTN-1:0]     o_btn_press,
  input  logic [4*NUM_HEX-1:0]   i_hex_val,
  input  logic [NUM_HEX-1:0]     i_hex_blank,
  output logic [7*NUM_HEX-1:0]   o_hex,
  input  logic [NUM_LEDR-1:0]    i_ledr,
  input  logic [NUM_LEDG-1:0]    i_ledg,
  output logic [NUM_LEDR-1:0]    o_ledr,
  output logic [NUM_LEDG-1:0]    o_ledg
);

  localparam int unsigned NumIn = NUM_SW + NUM_BTN;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);
  // Idle pin levels: switches low, buttons released (pin high). The same mask
  // inverts the button bits after synchronisation.
  localparam logic [NumIn-1:0] InIdle = {{NUM_BTN{1'b1}}, {NUM_SW{1'b0}}};
  localparam logic [6:0] SegOff = HEX_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7*NUM_HEX-1:0] HexOff = {NUM_HEX{SegOff}};

  if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 1");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce (switches and buttons share one vector)
  // ---------------------------------------------------------------------------
  logic [NumIn-1:0] sync1_q, sync2_q, in_syn;
  logic [NumIn-1:0] stable_q, stable_d;
  logic [DbW-1:0]   db_cnt_q [NumIn];
  logic [DbW-1:0]   db_cnt_d [NumIn];

  assign in_syn = sync2_q ^ InIdle;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NumIn; i++) begin
      db_cnt_d[i] = '0;
      if (in_syn[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = in_syn[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press pulses
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_q, btn_prev_q, press_q, press_d;

  assign btn_q = stable_q[NumIn-1 -: NUM_BTN];

`ifdef BOARD_IO_AUTOREPEAT_EN
  localparam int unsigned RepMax =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepPeriod = RepW'(REPEAT_PERIOD);

  logic [NUM_BTN-1:0] btn_d;
  logic [RepW-1:0]    rep_cnt_q [NUM_BTN];
  logic [RepW-1:0]    rep_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rep_on_q, rep_on_d, rep_fire;

  assign btn_d = stable_d[NumIn-1 -: NUM_BTN];

  // The counter holds the number of cycles since the last pulse. Both the
  // current and the next debounced level must be high, so the counter clears
  // on the release edge itself and no pulse can land there.
  always_comb begin
    rep_on_d = rep_on_q;
    rep_fire = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rep_cnt_d[i] = rep_cnt_q[i];
      if (!(btn_q[i] && btn_d[i])) begin
        rep_cnt_d[i] = '0;
        rep_on_d[i]  = 1'b0;
      end else if (!btn_prev_q[i]) begin
        // The initial press pulse is being issued on this edge.
        rep_cnt_d[i] = RepW'(1);
        rep_on_d[i]  = 1'b0;
      end else if (rep_cnt_q[i] == (rep_on_q[i] ? RepPeriod : RepDelay)) begin
        rep_fire[i]  = 1'b1;
        rep_cnt_d[i] = RepW'(1);
        rep_on_d[i]  = 1'b1;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rep_on_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= '0;
    end else begin
      rep_on_q <= rep_on_d;
      for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end

  assign press_d = (btn_q & ~btn_prev_q) | rep_fire;
`else
  assign press_d = btn_q & ~btn_prev_q;
`endif

  // ---------------------------------------------------------------------------
  // Seven-segment decode
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = '0;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [7*NUM_HEX-1:0] hex_q, hex_d;

  always_comb begin
    logic [6:0] seg;
    seg   = '0;
    hex_d = '0;
    for (int k = 0; k < NUM_HEX; k++) begin
      seg = i_hex_blank[k] ? 7'h00 : seg_decode(i_hex_val[4*k +: 4]);
      hex_d[7*k +: 7] = HEX_ACTIVE_LOW ? ~seg : seg;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [NUM_LEDR-1:0] ledr_q;
  logic [NUM_LEDG-1:0] ledg_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q    <= InIdle;
      sync2_q    <= InIdle;
      stable_q   <= '0;
      for (int i = 0; i < NumIn; i++) db_cnt_q[i] <= '0;
      btn_prev_q <= '0;
      press_q    <= '0;
      hex_q      <= HexOff;
      ledr_q     <= '0;
      ledg_q     <= '0;
    end else begin
      sync1_q    <= {i_btn_raw, i_sw_raw};
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      for (int i = 0; i < NumIn; i++) db_cnt_q[i] <= db_cnt_d[i];
      btn_prev_q <= btn_q;
      press_q    <= press_d;
      hex_q      <= hex_d;
      ledr_q     <= i_ledr;
      ledg_q     <= i_ledg;
    end
  end

  assign o_sw        = stable_q[NUM_SW-1:0];
  assign o_btn       = btn_q;
  assign o_btn_press = press_q;
  assign o_hex       = hex_q;
  assign o_ledr      = ledr_q;
  assign o_ledg      = ledg_q;

endmodule
